intr_ctrl: RTL and testbench

Interrupt sequencer that sits between four external interrupt lines, the CP0 register file and the core's PC logic. It synchronises and latches requests and picks the highest-priority enabled one, gated by the CP0 status fields. It then drives the CP0 EPC write port and a PC redirect into the handler vector. On `eret` it redirects back to the saved EPC. Single-level, non-nested service.

---
 rtl/intr_ctrl_pkg.sv | 34 +++
 rtl/intr_ctrl_sync.sv | 29 ++
 rtl/intr_ctrl.sv | 130 +++++++++++++
 tb/tb_intr_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/intr_ctrl_pkg.sv
// intr_ctrl_pkg: shared definitions for the interrupt sequencer.
//   - default instruction address width and handler vector layout
//   - CP0 register numbers the sequencer interacts with
//   - FSM state encoding
//   - fixed-priority encoder (line 0 highest)
package intr_ctrl_pkg;

  localparam int IM_ADDR_BIT_DEF = 10;
  localparam int NUM_IRQ         = 4;
  localparam int IRQ_IDX_W       = 2;

  // CP0 register numbers (status holds IE/IM, EPC holds the return PC)
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam logic [IM_ADDR_BIT_DEF-1:0] VEC_BASE_DEF   = 10'h100;
  localparam logic [IM_ADDR_BIT_DEF-1:0] VEC_STRIDE_DEF = 10'h010;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTER   = 2'd1,
    ST_SERVICE = 2'd2,
    ST_EXIT    = 2'd3
  } intr_state_e;

  // Lowest set index wins; scanning downward lets the lowest index overwrite.
  function automatic logic [IRQ_IDX_W-1:0] prio_idx(input logic [NUM_IRQ-1:0] req);
    prio_idx = '0;
    for (int i = NUM_IRQ-1; i >= 0; i--)
      if (req[i]) prio_idx = IRQ_IDX_W'(i);
  endfunction

endpackage

// File: rtl/intr_ctrl_sync.sv
// irq_sync_edge: one interrupt line's 2-FF synchroniser plus rising-edge detect.
//   clk, rst_n : clock, async active-low reset
//   irq_i      : raw asynchronous line
//   edge_o     : one-cycle pulse when the synchronised line goes 0 -> 1
module irq_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_i,
  output logic edge_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= irq_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // Combinational so the pending register is the third stage of latency.
  assign edge_o = sync_q & ~prev_q;

endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: single-level interrupt sequencer between four IRQ lines, CP0 and
// the PC logic.
//   clk, rst_n              : clock, async active-low reset
//   irq_in[3:0]             : raw interrupt lines (rising edge significant)
//   intr_en, intr_mask[3:0] : CP0 status global enable / per-line mask
//   pc_next, epc_rd         : return address to save / current CP0 EPC
//   eret, pipe_stall        : core retiring eret / core cannot redirect
//   epc_w_en, epc_w_data    : CP0 EPC write port
//   redirect, redirect_addr : PC override
//   pending, in_service     : latched requests / one-hot line in service
//   busy                    : sequencer not idle
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int                     IM_ADDR_BIT = IM_ADDR_BIT_DEF,
  parameter logic [IM_ADDR_BIT-1:0] VEC_BASE    = IM_ADDR_BIT'(10'h100),
  parameter logic [IM_ADDR_BIT-1:0] VEC_STRIDE  = IM_ADDR_BIT'(10'h010)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_IRQ-1:0]     irq_in,
  input  logic                   intr_en,
  input  logic [NUM_IRQ-1:0]     intr_mask,
  input  logic [IM_ADDR_BIT-1:0] pc_next,
  input  logic [IM_ADDR_BIT-1:0] epc_rd,
  input  logic                   eret,
  input  logic                   pipe_stall,
  output logic                   epc_w_en,
  output logic [IM_ADDR_BIT-1:0] epc_w_data,
  output logic                   redirect,
  output logic [IM_ADDR_BIT-1:0] redirect_addr,
  output logic [NUM_IRQ-1:0]     pending,
  output logic [NUM_IRQ-1:0]     in_service,
  output logic                   busy
);

  logic [NUM_IRQ-1:0]     edge_v;
  logic [NUM_IRQ-1:0]     pending_q, pending_d, clr;
  logic [NUM_IRQ-1:0]     sel_oh;
  logic [IRQ_IDX_W-1:0]   sel_q, sel_d;
  logic [IM_ADDR_BIT-1:0] ret_q, ret_d;
  logic [IM_ADDR_BIT-1:0] vec_addr;
  logic                   eligible;
  intr_state_e            state_q, state_d;

  for (genvar n = 0; n < NUM_IRQ; n++) begin : g_sync
    irq_sync_edge u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .irq_i (irq_in[n]),
      .edge_o(edge_v[n])
    );
  end

  // A same-line edge arriving in the clear cycle re-arms the bit.
  assign pending_d = (pending_q & ~clr) | edge_v;
  assign eligible  = intr_en & (|(pending_q & intr_mask));
  assign vec_addr  = VEC_BASE + VEC_STRIDE * IM_ADDR_BIT'(sel_q);

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      sel_oh[i] = (sel_q == IRQ_IDX_W'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      ret_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ret_q     <= ret_d;
      pending_q <= pending_d;
    end
  end

  // Strobes are decoded from state, so each transition yields exactly one
  // pulse regardless of how long a stall holds the state.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    ret_d         = ret_q;
    clr           = '0;
    epc_w_en      = 1'b0;
    epc_w_data    = '0;
    redirect      = 1'b0;
    redirect_addr = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (eligible && !pipe_stall) begin
          state_d = ST_ENTER;
          sel_d   = prio_idx(pending_q & intr_mask);
        end
      end
      // Entry is committed once here: enable/mask changes no longer abort it.
      ST_ENTER: begin
        if (!pipe_stall) begin
          epc_w_en      = 1'b1;
          epc_w_data    = pc_next;
          redirect      = 1'b1;
          redirect_addr = vec_addr;
          clr           = sel_oh;
          state_d       = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (eret) begin
          ret_d   = epc_rd;
          state_d = ST_EXIT;
        end
      end
      ST_EXIT: begin
        if (!pipe_stall) begin
          redirect      = 1'b1;
          redirect_addr = ret_q;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pending    = pending_q;
  assign in_service = (state_q == ST_SERVICE) ? sel_oh : '0;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] irq_in;
  logic       intr_en;
  logic [3:0] intr_mask;
  logic [9:0] pc_next, epc_rd;
  logic       eret, pipe_stall;
  logic       epc_w_en, redirect, busy;
  logic [9:0] epc_w_data, redirect_addr;
  logic [3:0] pending, in_service;

  int n_chk = 0;
  int n_err = 0;

  intr_ctrl dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .intr_en(intr_en),
    .intr_mask(intr_mask), .pc_next(pc_next), .epc_rd(epc_rd), .eret(eret),
    .pipe_stall(pipe_stall), .epc_w_en(epc_w_en), .epc_w_data(epc_w_data),
    .redirect(redirect), .redirect_addr(redirect_addr), .pending(pending),
    .in_service(in_service), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; irq_in = '0; intr_en = 1'b0; intr_mask = '0;
    pc_next = '0; epc_rd = '0; eret = 1'b0; pipe_stall = 1'b0;
    step(2);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {epc_w_en, redirect, epc_w_data, redirect_addr}, 0);
    chk("rst_pend", {pending, in_service}, 0);
    rst_n = 1'b1;

    // ---- single IRQ on line 2 ----
    intr_mask = 4'b0100; intr_en = 1'b1; pc_next = 10'h044;
    irq_in = 4'b0100;
    step(2);
    chk("l2_pend_early", pending, 4'b0000);
    step(1);
    chk("l2_pend_3cyc", pending, 4'b0100);
    chk("l2_idle_nostrobe", {busy, epc_w_en, redirect}, 0);
    step(1);
    chk("l2_enter_epcw", {epc_w_en, epc_w_data}, {1'b1, 10'h044});
    chk("l2_enter_redir", {redirect, redirect_addr}, {1'b1, 10'h120});
    step(1);
    chk("l2_service_insvc", in_service, 4'b0100);
    chk("l2_service_pend", pending, 4'b0000);
    chk("l2_service_strobes", {epc_w_en, redirect}, 0);
    irq_in = '0; epc_rd = 10'h044; eret = 1'b1;
    step(1);
    eret = 1'b0;
    chk("l2_exit_redir", {redirect, redirect_addr}, {1'b1, 10'h044});
    chk("l2_exit_insvc", in_service, 0);
    step(1);
    chk("l2_idle_busy", {busy, redirect}, 0);

    // ---- eret while idle ----
    eret = 1'b1;
    step(1);
    eret = 1'b0;
    chk("eret_idle", {busy, redirect, epc_w_en}, 0);

    // ---- priority: lines 1 and 3 together ----
    intr_mask = 4'hF; pc_next = 10'h07C;
    irq_in = 4'b1010;
    step(3);
    chk("pri_pend", pending, 4'b1010);
    step(1);
    chk("pri_enter_vec", {redirect, redirect_addr}, {1'b1, 10'h110});
    chk("pri_enter_epc", epc_w_data, 10'h07C);
    step(1);
    chk("pri_insvc", in_service, 4'b0010);
    chk("pri_pend_left", pending, 4'b1000);
    step(2);
    chk("pri_hold_service", {busy, epc_w_en, redirect, in_service}, {3'b100, 4'b0010});
    epc_rd = 10'h200; eret = 1'b1;
    step(1);
    eret = 1'b0;
    chk("pri_exit_redir", {redirect, redirect_addr}, {1'b1, 10'h200});
    step(1);
    chk("pri_idle_gap", {busy, redirect, epc_w_en}, 0);
    step(1);
    chk("pri_l3_enter", {epc_w_en, redirect, redirect_addr}, {2'b11, 10'h130});
    step(1);
    chk("pri_l3_insvc", {in_service, pending}, {4'b1000, 4'b0000});
    irq_in = '0; eret = 1'b1;
    step(1);
    eret = 1'b0;
    step(1);
    chk("pri_l3_done", busy, 0);

    // ---- masking / enable, then stall during entry ----
    intr_mask = 4'b0000; intr_en = 1'b1; irq_in = 4'b0001;
    step(3);
    chk("mask_pend", pending, 4'b0001);
    irq_in = 4'b0000;
    step(2);
    chk("mask_blocked", {busy, epc_w_en, redirect, pending}, {3'b000, 4'b0001});
    intr_mask = 4'b0001; intr_en = 1'b0;
    step(2);
    chk("en_blocked", {busy, epc_w_en, pending}, {2'b00, 4'b0001});
    intr_en = 1'b1; pc_next = 10'h0A8;
    step(1);
    chk("unmask_enter", {busy, epc_w_en}, 2'b11);
    // stall three cycles in ENTER; drop enable meanwhile (entry is committed)
    pipe_stall = 1'b1; intr_en = 1'b0;
    #1;
    chk("stall1_nostrobe", {epc_w_en, redirect}, 0);
    step(1);
    irq_in = 4'b0001; // edge reaches pending exactly at the clear edge
    #1;
    chk("stall2_nostrobe", {epc_w_en, redirect, busy}, 3'b001);
    step(1);
    chk("stall3_nostrobe", {epc_w_en, redirect, in_service}, 0);
    step(1);
    pipe_stall = 1'b0;
    #1;
    chk("unstall_epcw", {epc_w_en, epc_w_data}, {1'b1, 10'h0A8});
    chk("unstall_redir", {redirect, redirect_addr}, {1'b1, 10'h100});
    step(1);
    chk("unstall_single_pulse", {epc_w_en, redirect}, 0);
    chk("setwins_insvc", in_service, 4'b0001);
    chk("setwins_pend", pending, 4'b0001);

    // ---- async reset mid-service ----
    rst_n = 1'b0;
    #1;
    chk("arst_outs", {busy, epc_w_en, redirect, epc_w_data, redirect_addr}, 0);
    chk("arst_pend", {pending, in_service}, 0);
    irq_in = '0;
    step(1);
    rst_n = 1'b1;
    step(2);
    chk("post_rst_idle", {busy, pending}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
